// File: rtl/prescaler_timer_if.sv
// Bus bundle for prescaler_timer: control/config inputs and registered status outputs.
// The master side drives control; the slave side is the timer itself.
interface prescaler_timer_if #(
    parameter int unsigned PRESCALE_W = 16,
    parameter int unsigned COUNT_W    = 32
);
    logic                  enable;
    logic                  start;
    logic                  stop;
    logic                  periodic;
    logic [PRESCALE_W-1:0] prescaler;
    logic [COUNT_W-1:0]    load_value;
    logic [COUNT_W-1:0]    compare;
    logic                  match_irq_en;
    logic                  irq_clr;
    logic [COUNT_W-1:0]    count;
    logic                  running;
    logic                  tick;
    logic                  match;
    logic                  expired;
    logic                  irq;

    modport master (
        output enable, start, stop, periodic, prescaler, load_value, compare,
               match_irq_en, irq_clr,
        input  count, running, tick, match, expired, irq
    );

    modport slave (
        input  enable, start, stop, periodic, prescaler, load_value, compare,
               match_irq_en, irq_clr,
        output count, running, tick, match, expired, irq
    );
endinterface

// File: rtl/prescaler_timer.sv
// Prescaled down-counting timer with one-shot/periodic reload, compare match
// and a sticky interrupt. All outputs are registered.
module prescaler_timer #(
    parameter int unsigned PRESCALE_W = 16,
    parameter int unsigned COUNT_W    = 32
) (
    input logic              clk,
    input logic              rst,
    prescaler_timer_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q, state_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic                  tick_q, tick_d;
    logic                  match_q, match_d;
    logic                  expired_q, expired_d;
    logic                  irq_q, irq_d;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pcnt_d    = pcnt_q;
        tick_d    = 1'b0;
        match_d   = 1'b0;
        expired_d = 1'b0;
        irq_d     = irq_q;

        if (bus.stop) begin
            state_d = IDLE;
            pcnt_d  = '0;
        end else if (bus.start) begin
            state_d = RUN;
            count_d = bus.load_value;
            pcnt_d  = '0;
        end else if (state_q == RUN && bus.enable) begin
            // >= rather than == so a lowered prescaler fires immediately instead of wrapping
            if (pcnt_q >= bus.prescaler) begin
                pcnt_d = '0;
                tick_d = 1'b1;
                if (count_q != '0) begin
                    count_d = count_q - COUNT_W'(1);
                    match_d = (count_d == bus.compare);
                end else begin
                    expired_d = 1'b1;
                    if (bus.periodic) begin
                        count_d = bus.load_value;
                        match_d = (count_d == bus.compare);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end else begin
                pcnt_d = pcnt_q + PRESCALE_W'(1);
            end
        end

        // A setting event outranks a simultaneous clear
        if (expired_d || (match_d && bus.match_irq_en))
            irq_d = 1'b1;
        else if (bus.irq_clr)
            irq_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            pcnt_q    <= '0;
            tick_q    <= 1'b0;
            match_q   <= 1'b0;
            expired_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pcnt_q    <= pcnt_d;
            tick_q    <= tick_d;
            match_q   <= match_d;
            expired_q <= expired_d;
            irq_q     <= irq_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.running = (state_q == RUN);
    assign bus.tick    = tick_q;
    assign bus.match   = match_q;
    assign bus.expired = expired_q;
    assign bus.irq     = irq_q;
endmodule

// File: tb/tb_prescaler_timer.sv
// Directed bench for prescaler_timer with hand-computed expectations.
module tb_prescaler_timer;
    localparam int unsigned PRESCALE_W = 16;
    localparam int unsigned COUNT_W    = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_bad = 0;

    prescaler_timer_if #(.PRESCALE_W(PRESCALE_W), .COUNT_W(COUNT_W)) bus ();

    prescaler_timer #(.PRESCALE_W(PRESCALE_W), .COUNT_W(COUNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges and settle 1ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst              = 1'b1;
        bus.enable       = 1'b1;
        bus.start        = 1'b0;
        bus.stop         = 1'b0;
        bus.periodic     = 1'b0;
        bus.prescaler    = '0;
        bus.load_value   = '0;
        bus.compare      = 32'hFFFF_FFFF;
        bus.match_irq_en = 1'b0;
        bus.irq_clr      = 1'b0;
        step(2);
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("idle_flags", {bus.running, bus.tick, bus.match, bus.expired, bus.irq}, 0);
            check("idle_count", bus.count, 0);
        end

        // Periodic P=3 L=2; irq_clr coincides with the second expiry
        bus.prescaler = 3; bus.load_value = 2; bus.periodic = 1'b1; bus.compare = 100;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        check("per_start_count", bus.count, 2);
        check("per_start_run", bus.running, 1);
        for (int k = 1; k <= 25; k++) begin
            if (k == 24) bus.irq_clr = 1'b1;
            step(1);
            check("per_tick", bus.tick, (k % 4 == 0) ? 1 : 0);
            check("per_expired", bus.expired, (k == 12 || k == 24) ? 1 : 0);
            check("per_count", bus.count, 2 - ((k / 4) % 3));
            check("per_irq", bus.irq, (k >= 12 && k < 25) ? 1 : 0);
            if (k == 25) bus.irq_clr = 1'b0;
        end
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        check("per_stop_run", bus.running, 0);

        // One-shot P=0 L=5 C=3, match interrupt disabled
        bus.prescaler = 0; bus.load_value = 5; bus.periodic = 1'b0; bus.compare = 3;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        check("os_start_count", bus.count, 5);
        for (int k = 1; k <= 7; k++) begin
            step(1);
            check("os_count", bus.count, (k <= 5) ? 5 - k : 0);
            check("os_tick", bus.tick, (k <= 6) ? 1 : 0);
            check("os_match", bus.match, (k == 2) ? 1 : 0);
            check("os_expired", bus.expired, (k == 6) ? 1 : 0);
            check("os_running", bus.running, (k < 6) ? 1 : 0);
            check("os_irq", bus.irq, (k >= 6) ? 1 : 0);
        end
        bus.irq_clr = 1'b1;
        step(1);
        bus.irq_clr = 1'b0;
        check("os_irq_clr", bus.irq, 0);

        // Start load equal to C gives no match; a decrement to C with irq enabled does
        bus.load_value = 3; bus.compare = 3; bus.periodic = 1'b1; bus.match_irq_en = 1'b1;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        check("mi_start_match", bus.match, 0);
        check("mi_start_irq", bus.irq, 0);
        bus.compare = 1;
        step(1);
        check("mi_k1_match", bus.match, 0);
        step(1);
        check("mi_k2_count", bus.count, 1);
        check("mi_k2_match", bus.match, 1);
        check("mi_k2_irq", bus.irq, 1);
        bus.stop = 1'b1; bus.irq_clr = 1'b1; bus.match_irq_en = 1'b0;
        step(1);
        bus.stop = 1'b0; bus.irq_clr = 1'b0;
        check("mi_clr_irq", bus.irq, 0);

        // Stop holds the count; simultaneous start is ignored
        bus.prescaler = 7; bus.load_value = 10; bus.compare = 100;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(19);
        check("ss_pre_count", bus.count, 8);
        bus.start = 1'b1; bus.stop = 1'b1;
        step(1);
        bus.start = 1'b0; bus.stop = 1'b0;
        check("ss_stop_run", bus.running, 0);
        check("ss_stop_count", bus.count, 8);
        step(10);
        check("ss_hold_count", bus.count, 8);
        check("ss_hold_tick", bus.tick, 0);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        check("ss_restart_count", bus.count, 10);
        check("ss_restart_run", bus.running, 1);
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;

        // Lowering P mid-run, then enable low for 5 cycles
        bus.prescaler = 10; bus.load_value = 3; bus.periodic = 1'b0;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(8);
        bus.prescaler = 2;
        step(1);
        check("pd_tick", bus.tick, 1);
        check("pd_count", bus.count, 2);
        bus.enable = 1'b0;
        for (int k = 10; k <= 23; k++) begin
            if (k == 15) bus.enable = 1'b1;
            step(1);
            check("en_tick", bus.tick, (k == 17 || k == 20 || k == 23) ? 1 : 0);
            check("en_count", bus.count, (k < 17) ? 2 : (k < 20) ? 1 : 0);
            check("en_expired", bus.expired, (k == 23) ? 1 : 0);
        end
        check("en_irq", bus.irq, 1);

        // Reset mid-count wins over start
        bus.prescaler = 0; bus.load_value = 20; bus.periodic = 1'b1;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(3);
        check("rs_pre_count", bus.count, 17);
        rst = 1'b1; bus.start = 1'b1;
        step(1);
        rst = 1'b0; bus.start = 1'b0;
        check("rs_flags", {bus.running, bus.tick, bus.match, bus.expired, bus.irq}, 0);
        check("rs_count", bus.count, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/prescaler_timer.md
# prescaler_timer

Parametrised prescaled down-counting timer for the SoC timer subsystem. A programmable prescaler divides `clk` into prescale events. Each event decrements a reload counter. The block raises compare-match and expiry pulses and drives a sticky interrupt. It supports one-shot and periodic modes, start/stop control and a bypass (divide-by-1) prescale setting.

## Interface
Parameters:
- `PRESCALE_W`, 16: prescaler register width.
- `COUNT_W`, 32: timer counter width.

Ports:
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: global count enable. When low, the prescaler and counter freeze; start/stop are still honoured.
- `start` in 1: one-cycle pulse; loads the counter and runs.
- `stop` in 1: one-cycle pulse; halts the timer and holds the count.
- `periodic` in 1: 1 = reload on expiry, 0 = one-shot. Sampled at expiry.
- `prescaler` in PRESCALE_W: divide value P; event period is P+1 cycles; P=0 gives an event every cycle.
- `load_value` in COUNT_W: reload value L; sampled at start and at each periodic reload.
- `compare` in COUNT_W: match value C.
- `match_irq_en` in 1: lets match pulses set `irq`.
- `irq_clr` in 1: clears `irq`.
- `count` out COUNT_W: current counter value.
- `running` out 1: high in RUN state.
- `tick` out 1: one-cycle pulse per prescale event.
- `match` out 1: one-cycle pulse when the counter is updated to C.
- `expired` out 1: one-cycle pulse on expiry.
- `irq` out 1: sticky interrupt flag.

## Operation
- States:
  - IDLE: counter held, prescaler held at 0.
  - RUN: counting.
- Reset values: state IDLE; `count`=0; internal prescale count `pcnt`=0; `running`, `tick`, `match`, `expired` and `irq` all 0.
- IDLE to RUN on `start`: `count`<=L, `pcnt`<=0.
- `start` in RUN: restarts with the same actions.
- RUN to IDLE on `stop`: `count` holds and `pcnt`<=0.
- `start` and `stop` in the same cycle: `stop` wins.
- Prescale event `ev` = RUN && `enable` && `pcnt` >= P, with no start/stop that cycle.
  - On `ev`: `pcnt`<=0.
  - Otherwise, in RUN with `enable` high: `pcnt`<=`pcnt`+1.
  - The >= compare makes a mid-run decrease of P take effect at the next edge, with no wrap-around.
- Counter action on `ev`:
  - If `count` != 0: `count`<=`count`-1.
  - If `count` == 0 and `periodic`=1: expiry, `count`<=L, stay in RUN.
  - If `count` == 0 and `periodic`=0: expiry, `count` stays 0, go to IDLE.
- L=0 with `periodic`=1 expires on every event.
- `match` is set when `ev` occurs and the counter's next value equals C (decrement or reload). A start load equal to C does not produce `match`.
- `irq` set sources: `expired`, or `match` when `match_irq_en`=1.
  - Set has priority over `irq_clr` in the same cycle.
  - `irq_clr` clears `irq` otherwise.
- `rst` mid-operation: returns every register to its reset value on that edge, regardless of the other inputs.
- Width rules:
  - `pcnt` is PRESCALE_W bits wide.
  - Counter arithmetic is modulo 2^COUNT_W; decrement below 0 never occurs.
  - All compares are unsigned.

## Timing
- All outputs are registered.
- `tick`, `match` and `expired` are high for exactly one cycle, in the cycle where `count` shows the post-event value.
- `start` sampled at edge N gives:
  - `running`=1 and `count`=L from N.
  - First `tick` at edge N+P+1.
  - First `expired` at edge N+(L+1)(P+1).
- Periodic mode: expiries repeat every (L+1)(P+1) cycles.
- `enable` low for k cycles delays all subsequent events by exactly k cycles.
- `stop` at edge S: `running`=0 from S; no tick, match or expired pulse is produced at or after S.
- `irq` rises on the same edge as the pulse that sets it.

## Test plan
- Reset then idle for 20 cycles: all outputs stay 0 and `count`=0.
- P=3, L=2, `periodic`=1, `start` at edge N:
  - `tick` at N+4, N+8 and N+12.
  - `count` sequence 2, 1, 0, 2.
  - `expired` and `irq` at N+12, then again at N+24.
- P=0, L=5, `periodic`=0, C=3:
  - `tick` every cycle.
  - `match` at N+2.
  - `expired` at N+6, followed by IDLE with `count`=0.
  - `irq` set only by expiry while `match_irq_en`=0.
- P=7, L=10: `stop` at N+20 holds `count`=8. A `start` issued at the same edge as a `stop` is ignored; a later `start` reloads 10.
- P=10 with `pcnt`=8, P changed to 2: `ev` on the next edge. Hold `enable` low for 5 cycles: expiry shifts by exactly 5 cycles.
- `irq_clr` asserted in the same cycle as `expired`: `irq` remains 1; `irq_clr` the following cycle clears it.
- Assert `rst` mid-count: all outputs 0 on the next edge.
